// File: rtl/mtr_drv_pp_if.sv
// rtl/mtr_drv_pp_if.sv - control/gate bundle between commutation logic and mtr_drv_pp
interface mtr_drv_pp_if #(
    parameter int PWM_W  = 11,
    parameter int NUM_PH = 3,
    parameter int DEAD_W = 6
);
    logic [PWM_W-1:0]    duty;
    logic [2*NUM_PH-1:0] sel;
    logic [DEAD_W-1:0]   dead;
    logic                fault_in;
    logic                clr_fault;
    logic [NUM_PH-1:0]   high;
    logic [NUM_PH-1:0]   low;
    logic                period_start;
    logic                fault;

    modport master (
        output duty, sel, dead, fault_in, clr_fault,
        input  high, low, period_start, fault
    );

    modport slave (
        input  duty, sel, dead, fault_in, clr_fault,
        output high, low, period_start, fault
    );
endinterface

// File: rtl/mtr_drv_pp.sv
// rtl/mtr_drv_pp.sv - multi-phase PWM half-bridge driver with dead-time and fault latch
module mtr_drv_pp #(
    parameter int PWM_W  = 11,
    parameter int NUM_PH = 3,
    parameter int DEAD_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    mtr_drv_pp_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_HIGH_Z  = 2'b00,
        MODE_FORWARD = 2'b01,
        MODE_REVERSE = 2'b10,
        MODE_BRAKE   = 2'b11
    } mode_e;

    logic [PWM_W-1:0]    cnt_q, cnt_d;
    logic [PWM_W-1:0]    duty_sh_q, duty_sh_d;
    logic [2*NUM_PH-1:0] sel_sh_q, sel_sh_d;
    logic [NUM_PH-1:0]   prev_h_q, prev_h_d;
    logic [NUM_PH-1:0]   prev_l_q, prev_l_d;
    logic [DEAD_W-1:0]   dt_q [NUM_PH];
    logic [DEAD_W-1:0]   dt_d [NUM_PH];
    logic [NUM_PH-1:0]   high_q, high_d;
    logic [NUM_PH-1:0]   low_q, low_d;
    logic                period_start_q, period_start_d;
    logic                fault_q, fault_d;

    logic wrap;
    logic pwm;
    logic kill;

    assign wrap = (cnt_q == {PWM_W{1'b1}});
    assign pwm  = (cnt_q < duty_sh_q);
    // The raw request is blocked in the same cycle fault_in arrives, not a cycle later.
    assign kill = fault_q | bus.fault_in;

    always_comb begin : comb_next
        logic rh;
        logic rl;
        rh             = 1'b0;
        rl             = 1'b0;
        cnt_d          = cnt_q + PWM_W'(1);
        duty_sh_d      = wrap ? bus.duty : duty_sh_q;
        sel_sh_d       = wrap ? bus.sel  : sel_sh_q;
        period_start_d = wrap;
        fault_d        = bus.fault_in | (fault_q & ~bus.clr_fault);
        prev_h_d       = prev_h_q;
        prev_l_d       = prev_l_q;
        high_d         = '0;
        low_d          = '0;
        for (int i = 0; i < NUM_PH; i++) begin
            dt_d[i] = dt_q[i];
            case (mode_e'(sel_sh_q[2*i +: 2]))
                MODE_FORWARD: begin rh = pwm;  rl = ~pwm; end
                MODE_REVERSE: begin rh = ~pwm; rl = pwm;  end
                MODE_BRAKE:   begin rh = 1'b0; rl = pwm;  end
                default:      begin rh = 1'b0; rl = 1'b0; end
            endcase
            if (kill) begin
                prev_h_d[i] = 1'b0;
                prev_l_d[i] = 1'b0;
                dt_d[i]     = '0;
            end else if ({rh, rl} != {prev_h_q[i], prev_l_q[i]}) begin
                prev_h_d[i] = rh;
                prev_l_d[i] = rl;
                // The change cycle is the first dead cycle: the gap is exactly
                // dead cycles long and dead == 0 passes the request straight through.
                if (bus.dead == '0) begin
                    high_d[i] = rh;
                    low_d[i]  = rl;
                    dt_d[i]   = '0;
                end else begin
                    dt_d[i]   = bus.dead - DEAD_W'(1);
                end
            end else if (dt_q[i] != '0) begin
                dt_d[i] = dt_q[i] - DEAD_W'(1);
            end else begin
                high_d[i] = rh;
                low_d[i]  = rl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            duty_sh_q      <= '0;
            sel_sh_q       <= '0;
            prev_h_q       <= '0;
            prev_l_q       <= '0;
            high_q         <= '0;
            low_q          <= '0;
            period_start_q <= 1'b0;
            fault_q        <= 1'b0;
            for (int i = 0; i < NUM_PH; i++) begin
                dt_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            duty_sh_q      <= duty_sh_d;
            sel_sh_q       <= sel_sh_d;
            prev_h_q       <= prev_h_d;
            prev_l_q       <= prev_l_d;
            high_q         <= high_d;
            low_q          <= low_d;
            period_start_q <= period_start_d;
            fault_q        <= fault_d;
            for (int i = 0; i < NUM_PH; i++) begin
                dt_q[i] <= dt_d[i];
            end
        end
    end

    assign bus.high         = high_q;
    assign bus.low          = low_q;
    assign bus.period_start = period_start_q;
    assign bus.fault        = fault_q;
endmodule

// File: tb/tb_mtr_drv_pp.sv
// tb/tb_mtr_drv_pp.sv - directed vector bench for mtr_drv_pp
module tb_mtr_drv_pp;
    logic clk;
    logic rst;

    mtr_drv_pp_if #(.PWM_W(4), .NUM_PH(3), .DEAD_W(6)) bus ();

    mtr_drv_pp #(.PWM_W(4), .NUM_PH(3), .DEAD_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] duty;
        logic [5:0] sel;
        logic [5:0] dead;
        int h0, l0, h1, l1, h2, l2;
    } vec_t;

    vec_t vecs [10];
    int total = 0;
    int bad   = 0;
    int ovl   = 0;
    int hc [3];
    int lc [3];

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin
                if (bus.high[p] && bus.low[p]) ovl++;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic sync_ps(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.period_start) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_sync"}, int'(ok), 1);
    endtask

    task automatic measure(input int act_k, input logic [3:0] a_duty, input logic [5:0] a_sel);
        for (int p = 0; p < 3; p++) begin
            hc[p] = 0;
            lc[p] = 0;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step();
            for (int p = 0; p < 3; p++) begin
                hc[p] += int'(bus.high[p]);
                lc[p] += int'(bus.low[p]);
            end
            if (k == act_k) begin
                bus.duty = a_duty;
                bus.sel  = a_sel;
            end
        end
    endtask

    task automatic setup(input logic [3:0] d, input logic [5:0] s, input logic [5:0] dt, input string nm);
        bus.duty = d;
        bus.sel  = s;
        bus.dead = dt;
        sync_ps(nm);
        repeat (16) step();
    endtask

    initial begin
        int n;
        vecs[0] = '{4'd8,  6'b000001, 6'd2, 6, 6, 0, 0, 0, 0};
        vecs[1] = '{4'd12, 6'b000001, 6'd2, 10, 2, 0, 0, 0, 0};
        vecs[2] = '{4'd4,  6'b000010, 6'd0, 12, 4, 0, 0, 0, 0};
        vecs[3] = '{4'd5,  6'b000011, 6'd1, 0, 4, 0, 0, 0, 0};
        vecs[4] = '{4'd8,  6'b000000, 6'd2, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{4'd0,  6'b000001, 6'd2, 0, 16, 0, 0, 0, 0};
        vecs[6] = '{4'd15, 6'b000001, 6'd0, 15, 1, 0, 0, 0, 0};
        vecs[7] = '{4'd2,  6'b000001, 6'd3, 0, 11, 0, 0, 0, 0};
        vecs[8] = '{4'd8,  6'b111001, 6'd2, 6, 6, 6, 6, 0, 6};
        vecs[9] = '{4'd8,  6'b000100, 6'd5, 0, 0, 3, 3, 0, 0};

        rst           = 1'b1;
        bus.duty      = '0;
        bus.sel       = '0;
        bus.dead      = '0;
        bus.fault_in  = 1'b0;
        bus.clr_fault = 1'b0;
        step();
        step();
        chk("rst_high",  int'(bus.high), 0);
        chk("rst_low",   int'(bus.low), 0);
        chk("rst_fault", int'(bus.fault), 0);
        chk("rst_ps",    int'(bus.period_start), 0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            setup(vecs[v].duty, vecs[v].sel, vecs[v].dead, $sformatf("v%0d", v));
            measure(-1, 4'd0, 6'd0);
            chk($sformatf("v%0d_h0", v), hc[0], vecs[v].h0);
            chk($sformatf("v%0d_l0", v), lc[0], vecs[v].l0);
            chk($sformatf("v%0d_h1", v), hc[1], vecs[v].h1);
            chk($sformatf("v%0d_l1", v), lc[1], vecs[v].l1);
            chk($sformatf("v%0d_h2", v), hc[2], vecs[v].h2);
            chk($sformatf("v%0d_l2", v), lc[2], vecs[v].l2);
        end

        // Reverse with no dead time: low[0] is pwm of the previous count.
        setup(4'd4, 6'b000010, 6'd0, "rev");
        for (int c = 0; c < 16; c++) begin
            int e;
            if (c > 0) step();
            e = (((c + 15) % 16) < 4) ? 1 : 0;
            chk($sformatf("rev_low_c%0d", c),  int'(bus.low[0]), e);
            chk($sformatf("rev_high_c%0d", c), int'(bus.high[0]), 1 - e);
        end

        // Duty written mid-period only takes effect at the next period.
        setup(4'd8, 6'b000001, 6'd2, "dchg");
        measure(5, 4'd12, 6'b000001);
        chk("dchg_cur_h0", hc[0], 6);
        chk("dchg_cur_l0", lc[0], 6);
        step();
        chk("dchg_ps", int'(bus.period_start), 1);
        measure(-1, 4'd0, 6'd0);
        chk("dchg_nxt_h0", hc[0], 10);
        chk("dchg_nxt_l0", lc[0], 2);

        // Brake, then HIGH_Z written mid-period.
        setup(4'd5, 6'b000011, 6'd1, "brk");
        measure(8, 4'd5, 6'b000000);
        chk("brk_h0", hc[0], 0);
        chk("brk_l0", lc[0], 4);
        step();
        measure(-1, 4'd0, 6'd0);
        chk("hz_h0", hc[0], 0);
        chk("hz_l0", lc[0], 0);

        // Fault latch, blocked clear, real clear, dead-gap on resume.
        setup(4'd8, 6'b000001, 6'd2, "flt");
        repeat (4) step();
        chk("flt_pre_high", int'(bus.high[0]), 1);
        bus.fault_in = 1'b1;
        step();
        chk("flt_hi_c5",  int'(bus.high), 0);
        chk("flt_lo_c5",  int'(bus.low), 0);
        chk("flt_set_c5", int'(bus.fault), 1);
        bus.fault_in = 1'b0;
        step();
        chk("flt_hold_c6", int'(bus.fault), 1);
        chk("flt_out_c6",  int'(bus.high | bus.low), 0);
        bus.fault_in  = 1'b1;
        bus.clr_fault = 1'b1;
        step();
        chk("flt_both_c7", int'(bus.fault), 1);
        bus.fault_in  = 1'b0;
        bus.clr_fault = 1'b0;
        step();
        chk("flt_still_c8", int'(bus.fault), 1);
        bus.clr_fault = 1'b1;
        step();
        bus.clr_fault = 1'b0;
        chk("flt_clr_c9",  int'(bus.fault), 0);
        chk("flt_out_c9",  int'(bus.high | bus.low), 0);
        step();
        chk("flt_gap_c10", int'(bus.high | bus.low), 0);
        step();
        chk("flt_gap_c11", int'(bus.high | bus.low), 0);
        step();
        chk("flt_res_low_c12",  int'(bus.low[0]), 1);
        chk("flt_res_high_c12", int'(bus.high[0]), 0);

        // Asynchronous reset mid-operation.
        setup(4'd8, 6'b000001, 6'd2, "arst");
        chk("arst_pre_ps",  int'(bus.period_start), 1);
        chk("arst_pre_low", int'(bus.low[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_high", int'(bus.high), 0);
        chk("arst_low",  int'(bus.low), 0);
        chk("arst_ps",   int'(bus.period_start), 0);
        step();
        rst = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.period_start) begin
                n = i;
                break;
            end
        end
        chk("arst_ps_latency", n, 16);
        bus.fault_in = 1'b1;
        step();
        bus.fault_in = 1'b0;
        step();
        chk("arst_fault_pre", int'(bus.fault), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_fault", int'(bus.fault), 0);
        step();
        rst = 1'b0;
        step();

        chk("no_overlap", ovl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
